// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with ALUOp/funct decode, an iterative shift-add multiplier, valid/ready
// handshakes on both sides and illegal-encoding reporting.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      ALUOp_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
  typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpXor, OpSll, OpSra, OpMul, OpIll} op_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  op_e             op;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] acc_step;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [SHW-1:0]  shamt;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];
  assign shamt  = op_b_i[SHW-1:0];

  // Decode ALUOp/funct into an internal operation
  always_comb begin
    op = OpIll;
    unique case (ALUOp_i)
      2'b00: op = OpAdd;
      2'b01: begin
        if (funct_i == 10'b0100000_101) op = OpSra;
        else if (funct3 == 3'b000)      op = OpAdd;
        else                            op = OpIll;
      end
      2'b10: begin
        unique case ({funct7, funct3})
          10'b0000000_111: op = OpAnd;
          10'b0000000_100: op = OpXor;
          10'b0000000_001: op = OpSll;
          10'b0000000_000: op = OpAdd;
          10'b0100000_000: op = OpSub;
          10'b0000001_000: op = OpMul;
          default:         op = OpIll;
        endcase
      end
      default: op = OpIll;
    endcase
  end

  // Single-cycle datapath for every non-multiply operation
  always_comb begin
    alu_res = '0;
    unique case (op)
      OpAdd:   alu_res = op_a_i + op_b_i;
      OpSub:   alu_res = op_a_i - op_b_i;
      OpAnd:   alu_res = op_a_i & op_b_i;
      OpXor:   alu_res = op_a_i ^ op_b_i;
      OpSll:   alu_res = op_a_i << shamt;
      OpSra:   alu_res = $signed(op_a_i) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step of the multiplier
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state logic and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StDone);

    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            if (op == OpMul) begin
              // The accept edge performs bit 0 of the product (cleared accumulator plus the
              // first partial product) so the total latency is exactly XLEN edges.
              state_d  = StMul;
              acc_d    = op_b_i[0] ? op_a_i : '0;
              mcand_d  = op_a_i << 1;
              mplier_d = op_b_i >> 1;
              cnt_d    = CW'(1);
            end else begin
              state_d   = StDone;
              result_d  = alu_res;
              illegal_d = (op == OpIll);
            end
          end
        end
        StMul: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d   = StDone;
            result_d  = acc_step;
            illegal_d = 1'b0;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign result_o  = result_q;
  assign illegal_o = illegal_q;

endmodule
